// File: rtl/cpu_dbg_scanner.sv
// Run-control and debug-scan block: derives the CPU clock-enable from one board clock
// and scans per-channel probe words into a 32-bit display word.
module cpu_dbg_scanner #(
    parameter int CLK_DIV_W = 26,
    parameter int NCH       = 4,
    parameter int AW        = 6,
    parameter int DW        = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              run_sw,
    input  logic              step_btn,
    input  logic              slow,
    input  logic              bp_en,
    input  logic [31:0]       bp_pc,
    input  logic [31:0]       pc,
    input  logic [NCH-1:0]    ch_sel,
    input  logic [NCH*AW-1:0] ch_last,
    input  logic [NCH*DW-1:0] rd_data,
    output logic [AW-1:0]     rd_addr,
    output logic              cpu_ce,
    output logic              halted,
    output logic              bp_hit,
    output logic [31:0]       disp_data,
    output logic              disp_valid
);

    typedef enum logic {S_HALT, S_RUN} run_t;
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_SENT} scan_t;

    function automatic logic is_onehot(input logic [NCH-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    function automatic logic [2:0] enc(input logic [NCH-1:0] v);
        logic [2:0] r;
        r = '0;
        for (int k = 0; k < NCH; k++)
            if (v[k]) r = 3'(k);
        return r;
    endfunction

    logic [CLK_DIV_W-1:0] div;
    logic                 tick;
    logic                 step_btn_q;
    logic                 step_rise;
    logic                 bp_match;
    logic                 bp_pend;
    run_t                 run_st;
    scan_t                scan_st;
    logic [NCH-1:0]       ch_sel_q;
    logic [2:0]           ch_idx;
    logic [DW-1:0]        ch_word;
    logic [31:0]          ch_word32;
    logic [AW-1:0]        ch_lim;

    // Prescaler: tick is registered, so it lands one cycle after the counter match
    always_ff @(posedge clk) begin
        if (!rstn) begin
            div  <= '0;
            tick <= 1'b0;
        end else begin
            div  <= div + 1'b1;
            tick <= slow ? (&div) : (&div[CLK_DIV_W-3:0]);
        end
    end

    assign step_rise = step_btn & ~step_btn_q;
    assign bp_match  = bp_en && (pc == bp_pc);
    assign halted    = (run_st == S_HALT);

    // bp_pend keeps the core parked after a breakpoint until run_sw is cycled or a step is taken
    always_ff @(posedge clk) begin
        if (!rstn) begin
            run_st     <= S_HALT;
            step_btn_q <= 1'b0;
            cpu_ce     <= 1'b0;
            bp_hit     <= 1'b0;
            bp_pend    <= 1'b0;
        end else begin
            step_btn_q <= step_btn;
            cpu_ce     <= 1'b0;
            case (run_st)
                S_HALT: begin
                    if (step_rise) begin
                        cpu_ce  <= 1'b1;
                        bp_pend <= 1'b0;
                    end
                    if (!run_sw) begin
                        bp_pend <= 1'b0;
                    end else if (!bp_pend) begin
                        run_st <= S_RUN;
                        bp_hit <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (tick && bp_match) begin
                        run_st  <= S_HALT;
                        bp_hit  <= 1'b1;
                        bp_pend <= 1'b1;
                    end else if (!run_sw) begin
                        run_st <= S_HALT;
                    end else begin
                        cpu_ce <= tick;
                    end
                end
                default: run_st <= S_HALT;
            endcase
        end
    end

    assign ch_idx  = enc(ch_sel);
    assign ch_word = rd_data[ch_idx*DW +: DW];
    assign ch_lim  = ch_last[ch_idx*AW +: AW];

    generate
        if (DW >= 32) begin : g_trunc
            assign ch_word32 = ch_word[31:0];
        end else begin : g_zext
            assign ch_word32 = {{(32-DW){1'b0}}, ch_word};
        end
    endgenerate

    // Invalid select beats a channel change, which beats any tick-driven capture
    always_ff @(posedge clk) begin
        if (!rstn) begin
            scan_st    <= S_IDLE;
            rd_addr    <= '0;
            disp_data  <= '0;
            disp_valid <= 1'b0;
            ch_sel_q   <= '0;
        end else begin
            ch_sel_q   <= ch_sel;
            disp_valid <= 1'b0;
            if (!is_onehot(ch_sel)) begin
                scan_st <= S_IDLE;
                rd_addr <= '0;
            end else if (ch_sel != ch_sel_q) begin
                scan_st <= S_SCAN;
                rd_addr <= '0;
            end else begin
                case (scan_st)
                    S_IDLE: begin
                        scan_st <= S_SCAN;
                        rd_addr <= '0;
                    end
                    S_SCAN: begin
                        if (tick) begin
                            disp_data  <= ch_word32;
                            disp_valid <= 1'b1;
                            if (rd_addr == ch_lim) scan_st <= S_SENT;
                            else                   rd_addr <= rd_addr + 1'b1;
                        end
                    end
                    S_SENT: begin
                        if (tick) begin
                            disp_data  <= 32'hFFFF_FFFF;
                            disp_valid <= 1'b1;
                            rd_addr    <= '0;
                            scan_st    <= S_SCAN;
                        end
                    end
                    default: scan_st <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_dbg_scanner.sv
// Directed bench for cpu_dbg_scanner with a 6-bit prescaler (fast tick 16, slow tick 64).
module tb_cpu_dbg_scanner;

    localparam int CLK_DIV_W = 6;
    localparam int NCH = 4;
    localparam int AW  = 6;
    localparam int DW  = 32;

    logic              clk = 1'b0;
    logic              rstn;
    logic              run_sw;
    logic              step_btn;
    logic              slow;
    logic              bp_en;
    logic [31:0]       bp_pc;
    logic [31:0]       pc;
    logic [NCH-1:0]    ch_sel;
    logic [NCH*AW-1:0] ch_last;
    logic [NCH*DW-1:0] rd_data;
    logic [AW-1:0]     rd_addr;
    logic              cpu_ce;
    logic              halted;
    logic              bp_hit;
    logic [31:0]       disp_data;
    logic              disp_valid;

    int n_cmp = 0;
    int n_bad = 0;
    int ce_cnt = 0;
    int dv_cnt = 0;
    int n;
    bit pc_track = 1'b0;

    cpu_dbg_scanner #(.CLK_DIV_W(CLK_DIV_W), .NCH(NCH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rstn(rstn), .run_sw(run_sw), .step_btn(step_btn), .slow(slow),
        .bp_en(bp_en), .bp_pc(bp_pc), .pc(pc), .ch_sel(ch_sel), .ch_last(ch_last),
        .rd_data(rd_data), .rd_addr(rd_addr), .cpu_ce(cpu_ce), .halted(halted),
        .bp_hit(bp_hit), .disp_data(disp_data), .disp_valid(disp_valid)
    );

    always #5 clk = ~clk;

    // Probe model: channel k returns 0x100*k + address
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NCH; k++)
            rd_data[k*DW +: DW] = (32'(k) << 8) + 32'(rd_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
        if (cpu_ce) begin
            ce_cnt++;
            if (pc_track) pc = pc + 32'd4;
        end
        if (disp_valid) dv_cnt++;
    endtask

    task automatic wait_dv(input int lim, output int cnt);
        cnt = 0;
        do begin
            tick1();
            cnt++;
        end while (!disp_valid && cnt < lim);
        if (!disp_valid) chk("dv_timeout", {31'b0, disp_valid}, 32'd1);
    endtask

    initial begin
        rstn = 1'b0; run_sw = 1'b0; step_btn = 1'b0; slow = 1'b0;
        bp_en = 1'b0; bp_pc = 32'h0; pc = 32'h0;
        ch_sel = 4'b0010;
        ch_last = {6'd0, 6'd0, 6'd2, 6'd0};
        repeat (3) tick1();
        chk("rst_halted", {31'b0, halted}, 32'd1);
        chk("rst_bp_hit", {31'b0, bp_hit}, 32'd0);
        chk("rst_cpu_ce", {31'b0, cpu_ce}, 32'd0);
        chk("rst_disp_data", disp_data, 32'h0);
        chk("rst_disp_valid", {31'b0, disp_valid}, 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);

        // First tick 16 cycles after release, captured on the following edge
        rstn = 1'b1;
        ce_cnt = 0;
        wait_dv(40, n);
        chk("first_tick_lat", 32'(n), 32'd17);
        chk("scan0", disp_data, 32'h100);
        chk("scan0_addr", 32'(rd_addr), 32'd1);
        wait_dv(40, n);
        chk("tick_period", 32'(n), 32'd16);
        chk("scan1", disp_data, 32'h101);
        wait_dv(40, n);
        chk("scan2", disp_data, 32'h102);
        chk("scan2_addr_hold", 32'(rd_addr), 32'd2);
        wait_dv(40, n);
        chk("scan_marker", disp_data, 32'hFFFF_FFFF);
        chk("marker_addr", 32'(rd_addr), 32'd0);
        wait_dv(40, n);
        chk("scan_wrap", disp_data, 32'h100);
        chk("idle_run_no_ce", 32'(ce_cnt), 32'd0);
        chk("idle_run_halted", {31'b0, halted}, 32'd1);

        // Channel switch on the tick cycle
        wait_dv(40, n);
        chk("pre_switch_addr", 32'(rd_addr), 32'd2);
        repeat (15) tick1();
        ch_sel = 4'b1000;
        tick1();
        chk("switch_no_capture", {31'b0, disp_valid}, 32'd0);
        chk("switch_addr", 32'(rd_addr), 32'd0);
        wait_dv(40, n);
        chk("switch_lat", 32'(n), 32'd16);
        chk("switch_ch3", disp_data, 32'h300);

        // Invalid select parks the scanner
        ch_sel = 4'b0110;
        dv_cnt = 0;
        repeat (40) tick1();
        chk("invalid_no_dv", 32'(dv_cnt), 32'd0);
        chk("invalid_hold", disp_data, 32'h300);
        chk("invalid_addr", 32'(rd_addr), 32'd0);
        ch_sel = 4'b0010;
        wait_dv(40, n);
        chk("restore_idx0", disp_data, 32'h100);

        // Slow tick
        slow = 1'b1;
        wait_dv(200, n);
        wait_dv(200, n);
        chk("slow_period", 32'(n), 32'd64);
        slow = 1'b0;
        wait_dv(200, n);
        wait_dv(200, n);
        chk("fast_again", 32'(n), 32'd16);

        // Single step while halted
        ce_cnt = 0;
        step_btn = 1'b1;
        tick1();
        chk("step_ce_now", {31'b0, cpu_ce}, 32'd1);
        repeat (4) tick1();
        step_btn = 1'b0;
        repeat (3) tick1();
        chk("step_one_ce", 32'(ce_cnt), 32'd1);
        chk("step_halted", {31'b0, halted}, 32'd1);

        // Free run into a breakpoint at 0xC
        pc = 32'h0; bp_en = 1'b1; bp_pc = 32'h0C; pc_track = 1'b1;
        ce_cnt = 0;
        run_sw = 1'b1;
        repeat (80) tick1();
        chk("bp_ce_count", 32'(ce_cnt), 32'd3);
        chk("bp_halted", {31'b0, halted}, 32'd1);
        chk("bp_hit_set", {31'b0, bp_hit}, 32'd1);
        chk("bp_pc", pc, 32'h0C);
        repeat (40) tick1();
        chk("bp_pending_ce", 32'(ce_cnt), 32'd3);
        chk("bp_pending_halt", {31'b0, halted}, 32'd1);

        run_sw = 1'b0;
        repeat (2) tick1();
        step_btn = 1'b1;
        repeat (3) tick1();
        step_btn = 1'b0;
        repeat (2) tick1();
        chk("bp_step_ce", 32'(ce_cnt), 32'd4);
        chk("bp_step_pc", pc, 32'h10);
        chk("bp_step_halted", {31'b0, halted}, 32'd1);
        chk("bp_step_hit_kept", {31'b0, bp_hit}, 32'd1);

        run_sw = 1'b1;
        repeat (2) tick1();
        chk("resume_running", {31'b0, halted}, 32'd0);
        chk("resume_clear_hit", {31'b0, bp_hit}, 32'd0);
        repeat (40) tick1();
        chk("resume_ce", {31'b0, (ce_cnt >= 6)}, 32'd1);
        run_sw = 1'b0;
        repeat (2) tick1();
        chk("stop_halted", {31'b0, halted}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_dbg_scanner.md
# cpu_dbg_scanner

Parametrised run-control and debug-scan block for the single-cycle RISC-V core. It produces the CPU clock-enable (free-run, single-step, or breakpoint halt) from one board clock, and sequentially scans up to NCH probe sources (IM, RF, ALU taps, DM, …) into a 32-bit word for the 7-segment driver. Every probe source has its own programmable length. It replaces the fixed divider-tap and per-source scan counters in the CPU top.

## Interface
- CLK_DIV_W, 26: tick prescaler width; slow tick period 2^CLK_DIV_W cycles.
- NCH, 4: number of probe channels (1..8).
- AW, 6: probe address width.
- DW, 32: probe data width.

- clk  in  1  board clock; all logic on posedge.
- rstn  in  1  reset, synchronous, active-low.
- run_sw  in  1  1 = free-run, 0 = halt.
- step_btn  in  1  single-step request; level, already debounced.
- slow  in  1  1 = slow tick (2^CLK_DIV_W), 0 = fast tick (2^(CLK_DIV_W-2)).
- bp_en  in  1  breakpoint enable.
- bp_pc  in  32  breakpoint PC.
- pc  in  32  current CPU PC.
- ch_sel  in  NCH  one-hot channel select.
- ch_last  in  NCH*AW  per-channel last valid index; channel k is in bits [k*AW +: AW].
- rd_data  in  NCH*DW  per-channel probe data for rd_addr; combinational from the sources.
- rd_addr  out  AW  current scan address; registered.
- cpu_ce  out  1  one-cycle CPU clock-enable pulse.
- halted  out  1  run FSM is in HALT.
- bp_hit  out  1  sticky flag; set when the breakpoint stops the CPU.
- disp_data  out  32  display word.
- disp_valid  out  1  one-cycle pulse when disp_data updates.

## Operation
- **Prescaler:** counter `div` increments every cycle and wraps at 2^CLK_DIV_W.
  - tick = (slow ? div all-ones : div[CLK_DIV_W-3:0] all-ones), registered.
  - tick is a one-cycle pulse.
- **Step edge:** step_btn is registered; step_rise = step_btn & ~step_btn_q.
- **Run FSM:** states HALT, RUN.
  - HALT -> RUN when run_sw=1 and the breakpoint is not pending. bp_hit is cleared on this transition.
  - RUN -> HALT when run_sw=0.
  - RUN -> HALT on a tick where bp_en=1 and pc==bp_pc. That tick's cpu_ce is suppressed and bp_hit is set.
  - While run_sw stays 1 after a breakpoint halt, the FSM holds HALT ("pending"). It resumes only after run_sw goes 0 then 1, or on a step.
  - RUN: cpu_ce = tick, except when suppressed by the breakpoint.
  - HALT: cpu_ce = step_rise. A step ignores the breakpoint, so execution can step past it. The FSM stays in HALT after a step.
- **Scan FSM:** states IDLE, SCAN, SENT.
  - IDLE is entered when ch_sel is not one-hot (zero or multi-hot). In IDLE, rd_addr = 0, disp_data is held, and disp_valid = 0.
  - Any change of ch_sel (compared against its registered copy) forces rd_addr = 0 and state SCAN on the next cycle. This applies from any state.
  - SCAN, on tick: disp_data <= slice of channel c at rd_addr, and disp_valid is pulsed. Then:
    - if rd_addr == ch_last[c]: go to SENT and hold rd_addr;
    - else rd_addr + 1.
  - SENT, on tick: disp_data <= 32'hFFFFFFFF (end-of-list marker), disp_valid is pulsed, rd_addr <= 0, go to SCAN.
  - DW < 32: zero-extend. DW > 32: take the low 32 bits.
  - ch_last[c] = 0: the scan alternates index 0 and the marker.
- The scanner and run control share tick but are otherwise independent. Scanning continues while the CPU is halted.

## Timing
- **Reset (rstn=0 at a clk edge):**
  - div = 0.
  - Run FSM in HALT: halted = 1, bp_hit = 0.
  - cpu_ce = 0.
  - Scan FSM in IDLE: rd_addr = 0, disp_data = 0, disp_valid = 0.
  - step_btn_q = 0 and the ch_sel copy = 0.
  - Reset mid-scan or mid-run takes effect on the same edge.
- **Tick:** first tick occurs 2^(CLK_DIV_W-2) (fast) or 2^CLK_DIV_W (slow) cycles after reset release. Changing slow takes effect at the next counter match; there is no glitch pulse.
- **cpu_ce:** asserted in the cycle after the tick match (registered). step_btn rising at edge N gives cpu_ce high in cycle N+1, for exactly one cycle.
- **Scan latency:**
  - rd_data is sampled at the edge that ends the tick cycle.
  - disp_data and disp_valid are valid in the following cycle.
  - rd_addr advances on that same edge.
  - rd_data must therefore settle within one cycle of an rd_addr change.
- **Simultaneous events:**
  - ch_sel change and tick in the same cycle: the channel change wins. No capture occurs; rd_addr = 0.
  - run_sw=0 and breakpoint match on the same tick: go to HALT, with no cpu_ce and bp_hit set.
  - step_rise while in RUN: ignored.

## Test plan
- **Reset and prescaler:** set CLK_DIV_W=6, slow=0, and release reset.
  - Expect halted=1, disp_data=0, cpu_ce=0 throughout.
  - Expect the first tick at cycle 16 (counted from reset release), then every 16 cycles.
  - With slow=1, ticks every 64 cycles.
- **Single step:** with run_sw=0, pulse step_btn high for 5 cycles.
  - Expect exactly one cpu_ce cycle, one cycle after the rising edge.
  - halted stays 1.
- **Free run and breakpoint:** set run_sw=1, bp_en=1, bp_pc=0x0C, and let pc advance 0, 4, 8, 0xC per cpu_ce.
  - Expect 3 cpu_ce pulses, then halted=1 and bp_hit=1 with no fourth pulse.
  - A step then gives one cpu_ce.
  - Toggling run_sw 0→1 resumes and clears bp_hit.
- **Scan with wrap:** set ch_sel=4'b0010, ch_last[1]=2, and probe data = 0x100+addr.
  - Expect disp_data sequence 0x100, 0x101, 0x102, 0xFFFFFFFF, 0x100 on successive ticks, each with a disp_valid pulse.
- **Channel switch mid-scan:** at rd_addr=2, switch ch_sel to 4'b1000 in the same cycle as a tick.
  - Expect no capture, rd_addr=0, and the next tick displays channel 3 index 0.
- **Invalid select:** set ch_sel=4'b0110.
  - Expect IDLE: disp_data holds, no disp_valid, rd_addr=0.
  - Restoring one-hot restarts the scan from index 0.
